// File: rtl/busca_instrucao.sv
// Instruction fetch/sequencer: fetches instruction (and LDI immediate) words over a
// req/valid handshake and steps the control unit through four execution cycles.
module busca_instrucao #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_valid,
  input  logic [8:0]        mem_data,
  output logic [8:0]        instr,
  output logic [1:0]        cont,
  output logic [8:0]        immediate,
  output logic              exec_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b110;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [8:0]        instr_d, imm_d;
  logic [1:0]        cont_d;
  logic              mem_req_d, exec_valid_d, halted_d;

  // The address bus is the registered pc itself; no memory-side path reaches an output.
  assign mem_addr = pc;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= S_IDLE;
      pc         <= RESET_PC;
      instr      <= '0;
      immediate  <= '0;
      cont       <= 2'd0;
      mem_req    <= 1'b0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      instr      <= instr_d;
      immediate  <= imm_d;
      cont       <= cont_d;
      mem_req    <= mem_req_d;
      exec_valid <= exec_valid_d;
      halted     <= halted_d;
    end
  end

  // Next-state logic; status outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    instr_d = instr;
    imm_d   = immediate;
    cont_d  = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_valid) begin
          instr_d = mem_data;
          pc_d    = pc + ADDR_W'(1);
          case (mem_data[8:6])
            OP_LDI:  state_d = S_IMM;
            OP_HLT:  state_d = S_HALT;
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_IMM: begin
        if (mem_valid) begin
          imm_d   = mem_data;
          pc_d    = pc + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // run is only honoured at the instruction boundary (last step).
        if (cont == 2'd3) state_d = run ? S_FETCH : S_IDLE;
        else              cont_d  = cont + 2'd1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d    = (state_d == S_FETCH) || (state_d == S_IMM);
    exec_valid_d = (state_d == S_EXEC);
    halted_d     = (state_d == S_HALT);
  end

endmodule
